// File: rtl/riscv_pkg.sv
// Shared constants and types for the instruction fetch unit: opcodes, immediate
// formats, the NOP used as the reset IR value, and the fetch FSM states.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_SB,
    IMM_U,
    IMM_UJ,
    IMM_NONE
  } imm_type_e;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone
  } fetch_state_e;

  function automatic imm_type_e imm_type_of(input logic [6:0] op);
    imm_type_e t;
    case (op)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYS: t = IMM_I;
      OP_STORE:                         t = IMM_S;
      OP_BRANCH:                        t = IMM_SB;
      OP_LUI:                           t = IMM_U;
      OP_JAL:                           t = IMM_UJ;
      default:                          t = IMM_NONE;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: picks the immediate layout from the opcode and
// sign-extends it to XLEN bits (XLEN must be at least 32).
module imm_gen
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]     i_ir,
  output logic [XLEN-1:0] o_imm
);

  logic [31:0] w_imm32;

  always_comb begin
    w_imm32 = '0;
    case (imm_type_of(i_ir[6:0]))
      IMM_I:   w_imm32 = {{20{i_ir[31]}}, i_ir[31:20]};
      IMM_S:   w_imm32 = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
      IMM_SB:  w_imm32 = {{19{i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
      IMM_U:   w_imm32 = {i_ir[31:12], 12'b0};
      IMM_UJ:  w_imm32 = {{11{i_ir[31]}}, i_ir[31], i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  always_comb begin
    o_imm        = {XLEN{w_imm32[31]}};
    o_imm[31:0]  = w_imm32;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC and IR, fetches over a ready handshake, decodes IR fields.
// Optional macro FETCH_TIMEOUT_EN bounds the WAIT state to TIMEOUT_CYC cycles.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN        = 64,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     TIMEOUT_CYC = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            fetch_req,
  input  logic            pc_wr,
  input  logic            pc_sel,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_rd,
  input  logic [31:0]     mem_rdata,
  input  logic            mem_ready,
  output logic [XLEN-1:0] pc,
  output logic            busy,
  output logic            instr_valid,
  output logic            misaligned_err,
  output logic            fetch_err,
  output logic [6:0]      op_code,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm
);

  fetch_state_e    r_state, w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_ir;
  logic [XLEN-1:0] r_mem_addr;
  logic            r_mis_err;
  logic            w_ir_load;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC > 1 ? TIMEOUT_CYC : 2);
  logic [CntW-1:0] r_cnt;
  logic            w_timeout;
  logic            r_fetch_err;
`endif

  always_comb begin
    w_state_next = r_state;
    w_ir_load    = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    w_timeout    = 1'b0;
`endif
    case (r_state)
      StIdle: if (fetch_req) w_state_next = StWait;
      StWait: begin
        // A ready in the last counted cycle still completes the fetch.
        if (mem_ready) begin
          w_state_next = StDone;
          w_ir_load    = 1'b1;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (r_cnt == CntW'(TIMEOUT_CYC - 1)) begin
          w_state_next = StIdle;
          w_timeout    = 1'b1;
        end
`endif
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= StIdle;
      r_pc       <= RESET_PC;
      r_ir       <= NOP_INSTR;
      r_mem_addr <= '0;
      r_mis_err  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_mis_err <= pc_wr && pc_sel && (branch_target[1:0] != 2'b00);
      if (r_state == StIdle && fetch_req) r_mem_addr <= r_pc;
      if (w_ir_load) r_ir <= mem_rdata;
      // PC update is independent of the FSM; fetch above sees the old PC.
      if (pc_wr) begin
        if (!pc_sel) begin
          r_pc <= r_pc + XLEN'(4);
        end else if (branch_target[1:0] == 2'b00) begin
          r_pc <= branch_target;
        end
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt       <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      r_fetch_err <= w_timeout;
      if (r_state == StWait) r_cnt <= r_cnt + CntW'(1);
      else                   r_cnt <= '0;
    end
  end
  assign fetch_err = r_fetch_err;
`else
  assign fetch_err = 1'b0;
`endif

  assign mem_addr       = r_mem_addr;
  assign mem_rd         = (r_state == StWait);
  assign pc             = r_pc;
  assign busy           = (r_state != StIdle);
  assign instr_valid    = (r_state == StDone);
  assign misaligned_err = r_mis_err;

  assign op_code = r_ir[6:0];
  assign rd      = r_ir[11:7];
  assign funct3  = r_ir[14:12];
  assign rs1     = r_ir[19:15];
  assign rs2     = r_ir[24:20];
  assign funct7  = r_ir[31:25];

  imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .i_ir (r_ir),
    .o_imm(imm)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; inputs driven and outputs
// sampled on the falling edge. Covers the FETCH_TIMEOUT_EN build when defined.
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST, fetch_req, pc_wr, pc_sel, mem_ready;
  logic [63:0] branch_target;
  logic [31:0] mem_rdata;
  logic [63:0] mem_addr, pc, imm;
  logic        mem_rd, busy, instr_valid, misaligned_err, fetch_err;
  logic [6:0]  op_code, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;

  int errors = 0;
  int checks = 0;

`ifdef FETCH_TIMEOUT_EN
  localparam int Dly = 3;
`else
  localparam int Dly = 5;
`endif

  instr_fetch_unit #(
    .XLEN(64),
    .RESET_PC(64'h0),
    .TIMEOUT_CYC(4)
  ) dut (
    .CLK(CLK), .RST(RST), .fetch_req(fetch_req), .pc_wr(pc_wr), .pc_sel(pc_sel),
    .branch_target(branch_target), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc), .busy(busy),
    .instr_valid(instr_valid), .misaligned_err(misaligned_err), .fetch_err(fetch_err),
    .op_code(op_code), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  // Drives one complete fetch with immediate ready; returns in IDLE.
  task automatic do_fetch(input logic [31:0] w);
    fetch_req = 1'b1; tick(); fetch_req = 1'b0;
    mem_ready = 1'b1; mem_rdata = w; tick();
    mem_ready = 1'b0; mem_rdata = '0; tick();
  endtask

  task automatic test_reset();
    RST = 1'b1; tick(); tick(); RST = 1'b0;
    checks++; if (pc !== 64'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc); end
    checks++; if (mem_addr !== 64'h0) begin errors++; $display("FAIL reset_addr got %h want 0", mem_addr); end
    checks++; if ({mem_rd, busy, instr_valid, misaligned_err, fetch_err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b want 00000",
                         {mem_rd, busy, instr_valid, misaligned_err, fetch_err}); end
    checks++; if (op_code !== 7'h13 || rd !== 5'd0 || imm !== 64'd0) begin
      errors++; $display("FAIL reset_ir got op=%h rd=%0d imm=%h want op=13 rd=0 imm=0",
                         op_code, rd, imm); end
  endtask

  task automatic test_basic_fetch();
    fetch_req = 1'b1; tick(); fetch_req = 1'b0;
    checks++; if (!(busy === 1'b1 && mem_rd === 1'b1 && instr_valid === 1'b0 && mem_addr === 64'h0))
      begin errors++; $display("FAIL fetch_wait got busy=%b rd=%b iv=%b addr=%h want 1 1 0 0",
                               busy, mem_rd, instr_valid, mem_addr); end
    mem_ready = 1'b1; mem_rdata = 32'h00A0_0093; tick(); mem_ready = 1'b0; mem_rdata = '0;
    checks++; if (instr_valid !== 1'b1 || mem_rd !== 1'b0) begin
      errors++; $display("FAIL fetch_valid got iv=%b rd=%b want 1 0", instr_valid, mem_rd); end
    checks++; if (op_code !== 7'b0010011 || rd !== 5'd1 || imm !== 64'd10) begin
      errors++; $display("FAIL fetch_decode got op=%b rd=%0d imm=%h want 0010011 1 a",
                         op_code, rd, imm); end
    tick();
    checks++; if (instr_valid !== 1'b0 || busy !== 1'b0 || imm !== 64'd10) begin
      errors++; $display("FAIL fetch_after got iv=%b busy=%b imm=%h want 0 0 a",
                         instr_valid, busy, imm); end
  endtask

  task automatic test_pc_update();
    pc_wr = 1'b1; pc_sel = 1'b0; repeat (3) tick();
    checks++; if (pc !== 64'd12) begin errors++; $display("FAIL pc_inc got %h want c", pc); end
    pc_sel = 1'b1; branch_target = 64'h100; tick();
    checks++; if (pc !== 64'h100 || misaligned_err !== 1'b0) begin
      errors++; $display("FAIL pc_branch got pc=%h err=%b want 100 0", pc, misaligned_err); end
    branch_target = 64'h102; tick(); pc_wr = 1'b0;
    checks++; if (pc !== 64'h100 || misaligned_err !== 1'b1) begin
      errors++; $display("FAIL pc_misalign got pc=%h err=%b want 100 1", pc, misaligned_err); end
    tick();
    checks++; if (misaligned_err !== 1'b0) begin
      errors++; $display("FAIL misalign_pulse got %b want 0", misaligned_err); end
    pc_wr = 1'b1; pc_sel = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC; tick();
    pc_sel = 1'b0; tick(); pc_wr = 1'b0;
    checks++; if (pc !== 64'h0) begin errors++; $display("FAIL pc_wrap got %h want 0", pc); end
  endtask

  task automatic test_wait_hold();
    logic [63:0] exp_pc;
    pc_wr = 1'b1; pc_sel = 1'b1; branch_target = 64'h40; tick();
    pc_wr = 1'b0; fetch_req = 1'b1; tick();
    // Keep requesting and moving the PC while waiting; neither may disturb the fetch.
    pc_wr = 1'b1; pc_sel = 1'b0;
    for (int i = 0; i < Dly; i++) begin
      checks++; if (mem_rd !== 1'b1 || mem_addr !== 64'h40 || instr_valid !== 1'b0) begin
        errors++; $display("FAIL wait_hold[%0d] got rd=%b addr=%h iv=%b want 1 40 0",
                           i, mem_rd, mem_addr, instr_valid); end
      tick();
    end
    pc_wr = 1'b0;
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 64'h40) begin
      errors++; $display("FAIL wait_last got rd=%b addr=%h want 1 40", mem_rd, mem_addr); end
    mem_ready = 1'b1; mem_rdata = 32'hFE00_0EE3; tick();
    mem_ready = 1'b0; fetch_req = 1'b0;
    checks++; if (instr_valid !== 1'b1 || imm !== 64'hFFFF_FFFF_FFFF_FFFC || funct7 !== 7'h7F) begin
      errors++; $display("FAIL wait_valid got iv=%b imm=%h f7=%h want 1 fffffffffffffffc 7f",
                         instr_valid, imm, funct7); end
    tick();
    exp_pc = 64'h40 + 64'(4 * Dly);
    checks++; if (instr_valid !== 1'b0 || busy !== 1'b0 || pc !== exp_pc) begin
      errors++; $display("FAIL wait_noqueue got iv=%b busy=%b pc=%h want 0 0 %h",
                         instr_valid, busy, pc, exp_pc); end
  endtask

  task automatic test_imm_decode();
    do_fetch(32'h1234_50B7);
    checks++; if (imm !== 64'h1234_5000 || op_code !== 7'h37 || rd !== 5'd1) begin
      errors++; $display("FAIL imm_lui got imm=%h op=%h rd=%0d want 12345000 37 1", imm, op_code, rd); end
    do_fetch(32'h0011_3423);
    checks++; if (imm !== 64'd8 || funct3 !== 3'd3 || rs1 !== 5'd2 || rs2 !== 5'd1) begin
      errors++; $display("FAIL imm_sd got imm=%h f3=%0d rs1=%0d rs2=%0d want 8 3 2 1",
                         imm, funct3, rs1, rs2); end
    do_fetch(32'h0020_81B3);
    checks++; if (imm !== 64'd0 || rd !== 5'd3 || op_code !== 7'h33) begin
      errors++; $display("FAIL imm_rtype got imm=%h rd=%0d op=%h want 0 3 33", imm, rd, op_code); end
    do_fetch(32'hFF9F_F06F);
    checks++; if (imm !== 64'hFFFF_FFFF_FFFF_FFF8) begin
      errors++; $display("FAIL imm_jal got %h want fffffffffffffff8", imm); end
  endtask

  task automatic test_simultaneous();
    pc_wr = 1'b1; pc_sel = 1'b1; branch_target = 64'h8; tick();
    pc_sel = 1'b0; fetch_req = 1'b1; tick(); pc_wr = 1'b0; fetch_req = 1'b0;
    checks++; if (mem_addr !== 64'h8 || pc !== 64'd12 || busy !== 1'b1) begin
      errors++; $display("FAIL simul got addr=%h pc=%h busy=%b want 8 c 1", mem_addr, pc, busy); end
    RST = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h00A0_0093; tick();
    RST = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    checks++; if (busy !== 1'b0 || mem_rd !== 1'b0 || pc !== 64'h0 || mem_addr !== 64'h0) begin
      errors++; $display("FAIL rst_wait got busy=%b rd=%b pc=%h addr=%h want 0 0 0 0",
                         busy, mem_rd, pc, mem_addr); end
    checks++; if (op_code !== 7'h13 || imm !== 64'd0 || rd !== 5'd0) begin
      errors++; $display("FAIL rst_ir got op=%h imm=%h rd=%0d want 13 0 0", op_code, imm, rd); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin
      errors++; $display("FAIL rst_novalid got %b want 0", instr_valid); end
  endtask

  task automatic test_back_to_back();
    logic exp_iv;
    fetch_req = 1'b1; mem_ready = 1'b1;
    mem_rdata = {12'd0, 5'd0, 3'd0, 5'd1, 7'h13};
    for (int c = 1; c <= 6; c++) begin
      tick();
      exp_iv = (c == 2 || c == 5);
      checks++; if (instr_valid !== exp_iv) begin
        errors++; $display("FAIL b2b_valid[%0d] got %b want %b", c, instr_valid, exp_iv); end
      if (exp_iv) begin
        checks++; if (imm !== 64'(c - 1)) begin
          errors++; $display("FAIL b2b_imm[%0d] got %h want %0d", c, imm, c - 1); end
      end
      mem_rdata = {12'(c), 5'd0, 3'd0, 5'd1, 7'h13};
    end
    fetch_req = 1'b0; mem_ready = 1'b0; mem_rdata = '0; tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", busy); end
  endtask

  task automatic test_timeout();
`ifdef FETCH_TIMEOUT_EN
    fetch_req = 1'b1; tick(); fetch_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (busy !== 1'b1 || fetch_err !== 1'b0) begin
        errors++; $display("FAIL to_wait[%0d] got busy=%b err=%b want 1 0", i, busy, fetch_err); end
      tick();
    end
    checks++; if (fetch_err !== 1'b1 || busy !== 1'b0 || instr_valid !== 1'b0 || imm !== 64'd4) begin
      errors++; $display("FAIL to_abort got err=%b busy=%b iv=%b imm=%h want 1 0 0 4",
                         fetch_err, busy, instr_valid, imm); end
    tick();
    checks++; if (fetch_err !== 1'b0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL to_pulse got err=%b iv=%b want 0 0", fetch_err, instr_valid); end
`else
    logic stuck_ok;
    stuck_ok = 1'b1;
    fetch_req = 1'b1; tick(); fetch_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy !== 1'b1 || mem_rd !== 1'b1 || fetch_err !== 1'b0) stuck_ok = 1'b0;
      tick();
    end
    checks++; if (stuck_ok !== 1'b1) begin
      errors++; $display("FAIL wait_unbounded got %b want 1", stuck_ok); end
    mem_ready = 1'b1; mem_rdata = 32'h0050_0093; tick(); mem_ready = 1'b0;
    checks++; if (instr_valid !== 1'b1 || imm !== 64'd5 || fetch_err !== 1'b0) begin
      errors++; $display("FAIL wait_late got iv=%b imm=%h err=%b want 1 5 0",
                         instr_valid, imm, fetch_err); end
    tick();
`endif
  endtask

  initial begin
    RST = 1'b1; fetch_req = 1'b0; pc_wr = 1'b0; pc_sel = 1'b0; mem_ready = 1'b0;
    branch_target = '0; mem_rdata = '0;
    tick();
    test_reset();
    test_basic_fetch();
    test_pc_update();
    test_wait_hold();
    test_imm_decode();
    test_simultaneous();
    test_back_to_back();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
